dstream_uart_tx: RTL and testbench

- Sink-side consumer of the dstream valid/ready handshake.
- Accepts one DATA_W-bit sample per handshake on a dstream.in modport and serialises it onto a UART TX line as ceil(DATA_W/8) bytes, MSB byte first. Each byte is framed 8N1.
- Sits at the end of the microphone sample pipeline and streams samples to a host PC.
- Backpressures the upstream producer by holding ready low while a frame is in flight.

---
 rtl/dstream_uart_pkg.sv | 10 +
 rtl/dstream.sv | 8 +
 rtl/uart_byte_tx.sv | 81 ++++++++
 rtl/dstream_uart_tx.sv | 71 +++++++
 tb/tb_dstream_uart_tx.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dstream_uart_pkg.sv
// dstream_uart_pkg: shared FSM states and sizing helpers for the dstream UART transmitter.
package dstream_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  function automatic int calc_cpb(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud / 2) / baud);
  endfunction
  function automatic int nbytes(input int data_w);
    return (data_w + 7) / 8;
  endfunction
endpackage

// File: rtl/dstream.sv
// dstream: valid/ready sample stream; "in" is the sink view, "out" the source view.
interface dstream #(parameter int DATA_W = 16);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  modport in  (input valid, input data, output ready);
  modport out (output valid, output data, input ready);
endinterface

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: one 8N1 byte on a flopped tx line.
//   clk, rst_n : clock, async active-low reset
//   start_i    : load byte_i and begin a frame (honoured in IDLE or on the last stop-bit cycle)
//   byte_i     : byte to send, LSB first
//   tx_o       : serial line, idle high
//   done_o     : one-cycle pulse on the last cycle of the stop bit
module uart_byte_tx
  import dstream_uart_pkg::*;
#(
  parameter int CPB = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       done_o
);
  localparam int TW = (CPB > 1) ? $clog2(CPB) : 1;
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d, tick;
  always_comb begin
    tick    = tmr_q == TW'(CPB - 1);
    done_o  = state_q == STOP && tick;
    tmr_d   = (state_q == IDLE || tick) ? '0 : tmr_q + TW'(1);
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = START;
        tx_d    = 1'b0;
        sh_d    = byte_i;
        bit_d   = 4'd0;
      end
      START: if (tick) begin
        state_d = DATA;
        tx_d    = sh_q[0];
        bit_d   = 4'd1;
      end
      // sh_q[0] is the bit on the line; shift as each data bit retires
      DATA: if (tick) begin
        if (bit_q == 4'd8) begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_d   = 4'd9;
        end else begin
          tx_d  = sh_q[1];
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 4'd1;
        end
      end
      STOP: if (tick) begin
        state_d = start_i ? START : IDLE;
        tx_d    = !start_i;
        sh_d    = start_i ? byte_i : sh_q;
        bit_d   = 4'd0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end
  assign tx_o = tx_q;
endmodule

// File: rtl/dstream_uart_tx.sv
// dstream_uart_tx: dstream sink that sends each sample as MSB-first 8N1 bytes.
//   clk, rst_n : clock, async active-low reset
//   in         : dstream sink (valid/data in, registered ready out)
//   tx         : UART line, idle high
//   busy       : high while a sample is being transmitted
module dstream_uart_tx
  import dstream_uart_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic clk,
  input  logic rst_n,
  dstream.in   in,
  output logic tx,
  output logic busy
);
  localparam int CPB    = calc_cpb(CLK_HZ, BAUD);
  localparam int NBYTES = nbytes(DATA_W);
  localparam int SW     = NBYTES * 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  if (CPB < 2) begin : g_cpb_chk
    $error("dstream_uart_tx: clocks per bit must be at least 2");
  end
  if (DATA_W < 1) begin : g_w_chk
    $error("dstream_uart_tx: DATA_W must be at least 1");
  end
  logic          ready_q, ready_d, busy_q, busy_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] sh_q, sh_d, ext;
  logic          fire, last, done, start;
  logic [7:0]    byte_w;
  always_comb begin
    ext              = '0;
    ext[DATA_W-1:0]  = in.data;
    fire             = in.valid && ready_q;
    last             = idx_q == IW'(NBYTES - 1);
    // the next byte starts on the same edge the previous stop bit ends
    start            = fire || (done && !last);
    byte_w           = fire ? ext[SW-1 -: 8] : sh_q[SW-1 -: 8];
    sh_d             = start ? (fire ? ext : sh_q) << 8 : sh_q;
    idx_d            = fire ? '0 : (done && !last) ? idx_q + IW'(1) : idx_q;
    // after reset ready rises on the first edge since nothing can fire yet
    ready_d          = busy_q ? done && last : !fire;
    busy_d           = busy_q ? !(done && last) : fire;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end
  uart_byte_tx #(.CPB(CPB)) u_byte (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .byte_i (byte_w),
    .tx_o   (tx),
    .done_o (done)
  );
  assign in.ready = ready_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_dstream_uart_tx.sv
// tb_dstream_uart_tx: randomized self-check of dstream_uart_tx against a bit-level frame model.
module tb_dstream_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx16, busy16, tx12, busy12;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  dstream #(.DATA_W(16)) s16 ();
  dstream #(.DATA_W(12)) s12 ();
  dstream_uart_tx #(.DATA_W(16), .CLK_HZ(1_000_000), .BAUD(100_000)) dut16 (
    .clk(clk), .rst_n(rst_n), .in(s16), .tx(tx16), .busy(busy16));
  dstream_uart_tx #(.DATA_W(12), .CLK_HZ(200_000), .BAUD(100_000)) dut12 (
    .clk(clk), .rst_n(rst_n), .in(s12), .tx(tx12), .busy(busy12));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic rdy(input bit w);
    return w ? s12.ready : s16.ready;
  endfunction
  function automatic logic txo(input bit w);
    return w ? tx12 : tx16;
  endfunction
  function automatic logic bsy(input bit w);
    return w ? busy12 : busy16;
  endfunction
  function automatic logic [31:0] mask(input bit w);
    return w ? 32'hFFF : 32'hFFFF;
  endfunction
  task automatic drive(input bit w, input logic v, input logic [31:0] d);
    if (w) begin
      s12.valid = v;
      s12.data  = d[11:0];
    end else begin
      s16.valid = v;
      s16.data  = d[15:0];
    end
  endtask
  // called at a negedge; returns just after the handshake edge
  task automatic wait_hs(input bit w, output int n);
    n = 0;
    while (!rdy(w) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("hs_timeout", n, 0);
    @(posedge clk);
  endtask
  // model: sample -> 2 bytes MSB first, each 0,d0..d7,1 held cpb cycles from cycle 1
  task automatic run_frame(input bit w, input logic [31:0] val, input bit tog,
                           input logic nv, input logic [31:0] nd);
    int cpb, n, b, k, j;
    logic [7:0] ebyte, dec;
    logic ebit;
    cpb = w ? 2 : 10;
    n   = 2 * 10 * cpb;
    dec = '0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == 1) check("start_edge", txo(w), 0);
      if (c <= n && (c - 1) % cpb == cpb / 2) begin
        b     = (c - 1) / cpb;
        k     = b / 10;
        j     = b % 10;
        ebyte = 8'((val >> (8 * (1 - k))) & 32'hFF);
        ebit  = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : ebyte[j-1];
        check("tx_bit", txo(w), ebit);
        if (j >= 1 && j <= 8) dec[j-1] = txo(w);
        if (j == 9) check("byte", dec, ebyte);
        check("busy_frame", bsy(w), 1);
        check("ready_frame", rdy(w), 0);
      end
      if (tog) drive(w, (c < n) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom);
      else if (c == 1) drive(w, nv, nd);
      if (c == n + 1) begin
        check("ready_end", rdy(w), 1);
        check("busy_end", bsy(w), 0);
        check("tx_idle", txo(w), 1);
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bit w;
    logic [31:0] v, nxt;
    drive(0, 0, 0);
    drive(1, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_tx", tx16, 1);
    check("rst_ready", s16.ready, 0);
    check("rst_busy", busy16, 0);
    rst_n = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      check("idle_ready", s16.ready, 1);
      check("idle_tx", tx16, 1);
      check("idle_busy", busy16, 0);
    end
    check("idle_ready12", s12.ready, 1);
    drive(0, 1, 32'hA55A);
    wait_hs(0, n);
    run_frame(0, 32'hA55A, 0, 0, 0);
    drive(0, 1, 32'h1234);
    wait_hs(0, n);
    run_frame(0, 32'h1234, 0, 1, 32'hBEEF);
    wait_hs(0, n);
    check("b2b_wait", n, 0);
    run_frame(0, 32'hBEEF, 0, 0, 0);
    v = $urandom & 32'hFFFF;
    drive(0, 1, v);
    wait_hs(0, n);
    run_frame(0, v, 1, 0, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("post_tog_ready", s16.ready, 1);
      check("post_tog_tx", tx16, 1);
    end
    drive(0, 1, 32'h5A5A);
    wait_hs(0, n);
    drive(0, 0, 0);
    repeat (75) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx", tx16, 1);
    check("async_ready", s16.ready, 0);
    check("async_busy", busy16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", s16.ready, 1);
    check("rel_tx", tx16, 1);
    check("rel_busy", busy16, 0);
    drive(0, 1, 32'h00FF);
    wait_hs(0, n);
    run_frame(0, 32'h00FF, 0, 0, 0);
    drive(1, 1, 32'hABC);
    wait_hs(1, n);
    run_frame(1, 32'hABC, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      w = 1'($urandom_range(0, 1));
      v = $urandom & mask(w);
      drive(w, 1, v);
      wait_hs(w, n);
      for (int k = 0; k < 3; k++) begin
        nxt = $urandom & mask(w);
        run_frame(w, v, 0, k != 2, nxt);
        if (k != 2) begin
          wait_hs(w, n);
          check("rand_b2b_wait", n, 0);
          v = nxt;
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
